// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, renderer latency alignment and registered video output.
// Optional VGA_BG_CHECKER_EN replaces the flat background with a 32x32 checkerboard.
module vga_timing_gen #(
    parameter int          PIX_WIDTH    = 12,
    parameter int          H_ACTIVE     = 1280,
    parameter int          H_FP         = 48,
    parameter int          H_SYNC       = 112,
    parameter int          H_BP         = 248,
    parameter int          V_ACTIVE     = 1024,
    parameter int          V_FP         = 1,
    parameter int          V_SYNC       = 3,
    parameter int          V_BP         = 38,
    parameter bit          H_SYNC_POL   = 1'b1,
    parameter bit          V_SYNC_POL   = 1'b1,
    parameter int          DATA_LATENCY = 2,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 pix_valid_o,
    output logic                 frame_done_o,
    input  logic [23:0]          vga_data_i,
    input  logic                 vga_data_en_i,
    output logic [23:0]          vga_rgb_o,
    output logic                 vga_de_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [PIX_WIDTH-1:0] H_LAST = PIX_WIDTH'(H_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST = PIX_WIDTH'(V_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] H_ACT  = PIX_WIDTH'(H_ACTIVE);
    localparam logic [PIX_WIDTH-1:0] V_ACT  = PIX_WIDTH'(V_ACTIVE);
    localparam logic [PIX_WIDTH-1:0] HS_BEG = PIX_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [PIX_WIDTH-1:0] HS_END = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] VS_BEG = PIX_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [PIX_WIDTH-1:0] VS_END = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic [PIX_WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                 active, hs_act, vs_act;
    logic                 active_dl, hs_dl, vs_dl;
    logic [23:0]          bg, vga_rgb_q, vga_rgb_d;
    logic                 vga_de_q, vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;

    assign h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    assign v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_act       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_act       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign pix_x_o      = h_cnt_q;
    assign pix_y_o      = v_cnt_q;
    assign pix_valid_o  = active;
    assign frame_done_o = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

    // Decodes (and coordinates, for the checker) ride one shared delay line.
`ifdef VGA_BG_CHECKER_EN
    localparam int DW = 3 + 2 * PIX_WIDTH;
    logic [PIX_WIDTH-1:0] x_dl, y_dl;
    logic [DW-1:0]        tap, tap_d;
    assign tap = {h_cnt_q, v_cnt_q, active, hs_act, vs_act};
    assign {x_dl, y_dl, active_dl, hs_dl, vs_dl} = tap_d;
    assign bg = (x_dl[5] ^ y_dl[5]) ? 24'h202020 : BG_COLOR;
`else
    localparam int DW = 3;
    logic [DW-1:0] tap, tap_d;
    assign tap = {active, hs_act, vs_act};
    assign {active_dl, hs_dl, vs_dl} = tap_d;
    assign bg = BG_COLOR;
`endif

    generate
        if (DATA_LATENCY == 0) begin : g_wire
            assign tap_d = tap;
        end else begin : g_sr
            logic [DW-1:0] sr_q [DATA_LATENCY];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DATA_LATENCY; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= tap;
                    for (int i = 1; i < DATA_LATENCY; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign tap_d = sr_q[DATA_LATENCY-1];
        end
    endgenerate

    assign vga_rgb_d = !active_dl ? '0 : vga_data_en_i ? vga_data_i : bg;
    assign vga_hs_d  = hs_dl ? H_SYNC_POL : ~H_SYNC_POL;
    assign vga_vs_d  = vs_dl ? V_SYNC_POL : ~V_SYNC_POL;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vga_rgb_q <= '0;
            vga_de_q  <= 1'b0;
            vga_hs_q  <= ~H_SYNC_POL;
            vga_vs_q  <= ~V_SYNC_POL;
        end else begin
            vga_rgb_q <= vga_rgb_d;
            vga_de_q  <= active_dl;
            vga_hs_q  <= vga_hs_d;
            vga_vs_q  <= vga_vs_d;
        end
    end

    assign vga_rgb_o = vga_rgb_q;
    assign vga_de_o  = vga_de_q;
    assign vga_hs_o  = vga_hs_q;
    assign vga_vs_o  = vga_vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of raster, sync, latency and frame pulse on a reduced raster.
// Raster: H 40/4/6/6 (total 56, sync 44..49), V 34/1/2/3 (total 40, sync 35..36), frame 2240 cycles.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int F = 2240;
    localparam logic [23:0] BG = 24'h0000AA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pix_x, pix_y;
    logic        pix_valid, fd;
    logic [23:0] data, rgb, r1, r2;
    logic        en = 1'b1;
    logic        de, hs, vs;
    int          checks = 0, errors = 0, n = 0, cnt, fdc, des, vss, last;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_WIDTH(12), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .DATA_LATENCY(2), .BG_COLOR(BG)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pix_x_o(pix_x), .pix_y_o(pix_y),
        .pix_valid_o(pix_valid), .frame_done_o(fd),
        .vga_data_i(data), .vga_data_en_i(en),
        .vga_rgb_o(rgb), .vga_de_o(de), .vga_hs_o(hs), .vga_vs_o(vs)
    );

    // Fixed two-cycle renderer returning {y, x}.
    always @(posedge clk) begin
        r1 <= {pix_y, pix_x};
        r2 <= r1;
    end
    assign data = r2;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int t);
        while (n < t) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(pix_x), 0);
        chk("rst_y", 32'(pix_y), 0);
        chk("rst_valid", 32'(pix_valid), 1);
        chk("rst_fd", 32'(fd), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_hs", 32'(hs), 0);
        chk("rst_vs", 32'(vs), 0);
        rst = 1'b0;
        n = 0;
        chk("rel_x0", 32'(pix_x), 0);
        go(1);  chk("x1", 32'(pix_x), 1); chk("de_pipe1", 32'(de), 0);
        go(2);  chk("de_pipe2", 32'(de), 0); chk("hs_pipe2", 32'(hs), 0);
        go(3);  chk("de_first", 32'(de), 1);
        go(4);  chk("rgb_x1", 32'(rgb), 24'h000001);
        go(55); chk("x55", 32'(pix_x), 55); chk("y0", 32'(pix_y), 0);
        go(56); chk("hwrap_x", 32'(pix_x), 0); chk("hwrap_y", 32'(pix_y), 1);
        go(64); chk("rgb_5_1", 32'(rgb), 24'h001005); chk("valid_8_1", 32'(pix_valid), 1);
        go(98); chk("de_39_1", 32'(de), 1); chk("rgb_39_1", 32'(rgb), 24'h001027);
                chk("valid_42_1", 32'(pix_valid), 0);
        go(99); chk("de_40_1", 32'(de), 0); chk("rgb_40_1", 32'(rgb), 0);
        go(102); chk("hs_43", 32'(hs), 0);
        go(103); chk("hs_44", 32'(hs), 1);
        go(108); chk("hs_49", 32'(hs), 1);
        go(109); chk("hs_50", 32'(hs), 0);
        en = 1'b0;
        cnt = 0;
        repeat (56) begin go(n + 1); cnt += 32'(hs); end
        chk("hs_per_line", cnt, 6);
        go(181); chk("bg_10_3", 32'(rgb), BG); chk("de_10_3", 32'(de), 1);
`ifdef VGA_BG_CHECKER_EN
        go(204); chk("bg_33_3", 32'(rgb), 24'h202020);
`else
        go(204); chk("bg_33_3", 32'(rgb), BG);
`endif
        go(216); chk("bg_blank_45_3", 32'(rgb), 0);
        en = 1'b1;
        go(1909); chk("valid_5_34", 32'(pix_valid), 0); chk("fd_5_34", 32'(fd), 0);
        go(1912); chk("de_5_34", 32'(de), 0); chk("rgb_5_34", 32'(rgb), 0);
        go(1962); chk("vs_before", 32'(vs), 0);
        go(1963); chk("vs_rise", 32'(vs), 1);
        go(2074); chk("vs_last", 32'(vs), 1);
        go(2075); chk("vs_fall", 32'(vs), 0);
        go(2239); chk("corner_x", 32'(pix_x), 55); chk("corner_y", 32'(pix_y), 39);
        go(2240); chk("vwrap_xy", 32'({pix_y, pix_x}), 0); chk("vwrap_fd", 32'(fd), 0);
        fdc = 0; des = 0; vss = 0; last = -1;
        repeat (3 * F) begin
            go(n + 1);
            if (fd) begin
                fdc++;
                chk("fd_pos", 32'({pix_y, pix_x}), 24'h022000);
                if (last >= 0) chk("fd_period", n - last, F);
                last = n;
            end
            des += 32'(de);
            vss += 32'(vs);
        end
        chk("fd_count", fdc, 3);
        chk("de_count", des, 3 * 1360);
        chk("vs_count", vss, 3 * 112);
        go(n + 607);
        chk("pre_rst_x", 32'(pix_x), 47); chk("pre_rst_y", 32'(pix_y), 10);
        chk("pre_rst_hs", 32'(hs), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_xy", 32'({pix_y, pix_x}), 0);
        chk("mid_rst_hs", 32'(hs), 0);
        chk("mid_rst_de", 32'(de), 0);
        chk("mid_rst_rgb", 32'(rgb), 0);
        chk("mid_rst_vs", 32'(vs), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        cnt = 0;
        repeat (46) begin go(n + 1); cnt += 32'(hs); end
        chk("no_early_hs", cnt, 0);
        go(47); chk("post_rst_hs", 32'(hs), 1); chk("post_rst_x", 32'(pix_x), 47);
        chk("post_rst_y", 32'(pix_y), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
